// File: rtl/max_iter_recip_ctrl.sv
// -----------------------------------------------------------------------------
// max_iter_recip_ctrl
//
// Computes max_iter_recip = floor(2^RECIP_W / max_iterations) with a serial
// restoring divider, one quotient bit per clock. The colour-table stage uses
// the result to normalise pixel depth. Depth samples are forwarded only while
// the reciprocal matches the live max_iterations value. A stale reciprocal is
// never exposed as valid.
//
// Parameters
//   RECIP_W  reciprocal width; the result is unsigned Q0.RECIP_W
//   DEPTH_W  width of depth_in and max_iterations
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   max_iterations  run-time iteration limit N; may change in any cycle
//   depth_in        pixel depth from the iteration engine
//   depth_valid     depth_in is valid (upstream holds it until accepted)
//   depth_ready     depth_in is accepted this cycle (== recip_valid)
//   tbl_en          depth forwarded to the colour table this cycle
//   tbl_depth       depth forwarded to the colour table
//   max_iter_recip  floor(2^RECIP_W / N), saturated to all-ones; 0 when N == 0
//   recip_valid     max_iter_recip corresponds to the current max_iterations
//   busy            division in progress (LOAD or DIV)
// -----------------------------------------------------------------------------
module max_iter_recip_ctrl #(
  parameter int RECIP_W = 16,
  parameter int DEPTH_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DEPTH_W-1:0] max_iterations,
  input  logic [DEPTH_W-1:0] depth_in,
  input  logic               depth_valid,
  output logic               depth_ready,
  output logic               tbl_en,
  output logic [DEPTH_W-1:0] tbl_depth,
  output logic [RECIP_W-1:0] max_iter_recip,
  output logic               recip_valid,
  output logic               busy
);

  // The quotient of 2^RECIP_W / N needs RECIP_W+1 bits (N == 1 gives 2^RECIP_W).
  // The remainder stays below N, but the shifted partial remainder can reach
  // 2N-1, so the remainder carries one extra bit.
  localparam int QUOT_W = RECIP_W + 1;
  localparam int REM_W  = DEPTH_W + 1;
  localparam int CNT_W  = $clog2(RECIP_W + 1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(RECIP_W);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_DIV   = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [DEPTH_W-1:0]  r_n_q;
  logic [REM_W-1:0]    r_rem;
  logic [QUOT_W-1:0]   r_quot;
  logic [CNT_W-1:0]    r_cnt;
  logic [RECIP_W-1:0]  r_recip;

  logic                w_n_match;
  logic                w_div_bit;
  logic                w_last_step;
  logic [REM_W-1:0]    w_n_ext;
  logic [REM_W-1:0]    w_rem_shift;
  logic                w_sub_ok;
  logic [REM_W-1:0]    w_rem_next;
  logic [QUOT_W-1:0]   w_quot_next;
  logic [RECIP_W-1:0]  w_recip_sat;

  // ---------------------------------------------------------------------------
  // Restoring-division step for bit r_cnt of the dividend 2^RECIP_W.
  // Only the top dividend bit is set, so the shifted-in bit is 1 only on the
  // first step.
  // ---------------------------------------------------------------------------
  assign w_n_match   = (max_iterations == r_n_q);
  assign w_div_bit   = (r_cnt == CNT_TOP);
  assign w_last_step = (r_cnt == '0);
  assign w_n_ext     = {1'b0, r_n_q};
  assign w_rem_shift = (r_rem << 1) | REM_W'(w_div_bit);
  assign w_sub_ok    = (w_rem_shift >= w_n_ext);
  assign w_rem_next  = w_sub_ok ? (w_rem_shift - w_n_ext) : w_rem_shift;
  assign w_quot_next = (r_quot << 1) | QUOT_W'(w_sub_ok);
  // Only N == 1 produces a quotient of exactly 2^RECIP_W. That value cannot be
  // represented in Q0.RECIP_W, so the result is clamped to the largest code.
  assign w_recip_sat = w_quot_next[QUOT_W-1] ? '1 : w_quot_next[RECIP_W-1:0];

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    if (!rst_n) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and status outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first. A path that
    // leaves one unassigned would infer a latch.
    w_state_next = r_state;
    recip_valid  = 1'b0;
    busy         = 1'b1;

    case (r_state)
      S_LOAD: begin
        // The decision uses the value being latched into N_q on this edge.
        w_state_next = (max_iterations == '0) ? S_READY : S_DIV;
      end
      S_DIV: begin
        // A changed limit aborts the division, which restarts from LOAD.
        if (!w_n_match) begin
          w_state_next = S_LOAD;
        end else if (w_last_step) begin
          w_state_next = S_READY;
        end
      end
      S_READY: begin
        busy        = 1'b0;
        // Drops in the same cycle as the change, one cycle before the FSM
        // leaves READY.
        recip_valid = w_n_match;
        if (!w_n_match) begin
          w_state_next = S_LOAD;
        end
      end
      default: begin
        w_state_next = S_LOAD;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Divider datapath and result register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n_q   <= '0;
      r_rem   <= '0;
      r_quot  <= '0;
      r_cnt   <= '0;
      r_recip <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_n_q  <= max_iterations;
          r_rem  <= '0;
          r_quot <= '0;
          r_cnt  <= CNT_TOP;
          // A zero limit has no meaningful reciprocal and publishes 0 at once.
          if (max_iterations == '0) begin
            r_recip <= '0;
          end
        end
        S_DIV: begin
          // On an abort the partial state is discarded; LOAD reinitialises it.
          if (w_n_match) begin
            r_rem  <= w_rem_next;
            r_quot <= w_quot_next;
            r_cnt  <= w_last_step ? '0 : (r_cnt - 1'b1);
            // The published result changes only on entry to READY.
            if (w_last_step) begin
              r_recip <= w_recip_sat;
            end
          end
        end
        default: begin
          // READY: hold all values.
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Depth handshake. Depths pass through only while the reciprocal is current.
  // Upstream holds depth_in while depth_ready is low, so nothing is lost or
  // repeated.
  // ---------------------------------------------------------------------------
  assign depth_ready    = recip_valid;
  assign tbl_en         = depth_valid & depth_ready;
  assign tbl_depth      = depth_in;
  assign max_iter_recip = r_recip;

endmodule

// File: tb/tb_max_iter_recip_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for max_iter_recip_ctrl.
// A table of {N, expected reciprocal, expected latency} records is applied in a
// loop. Hand-written sequences cover reset release, abort mid-division,
// back-pressure across a limit change, and asynchronous reset mid-division.
// -----------------------------------------------------------------------------
module tb_max_iter_recip_ctrl;

  localparam int RECIP_W = 16;
  localparam int DEPTH_W = 10;
  localparam int BUDGET  = 40;

  logic               clk;
  logic               rst_n;
  logic [DEPTH_W-1:0] max_iterations;
  logic [DEPTH_W-1:0] depth_in;
  logic               depth_valid;
  logic               depth_ready;
  logic               tbl_en;
  logic [DEPTH_W-1:0] tbl_depth;
  logic [RECIP_W-1:0] max_iter_recip;
  logic               recip_valid;
  logic               busy;

  int n_tests;
  int n_fail;

  max_iter_recip_ctrl #(
    .RECIP_W(RECIP_W),
    .DEPTH_W(DEPTH_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .max_iterations(max_iterations),
    .depth_in      (depth_in),
    .depth_valid   (depth_valid),
    .depth_ready   (depth_ready),
    .tbl_en        (tbl_en),
    .tbl_depth     (tbl_depth),
    .max_iter_recip(max_iter_recip),
    .recip_valid   (recip_valid),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DEPTH_W-1:0] n;
    logic [RECIP_W-1:0] exp_recip;
    int                 exp_lat;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Called at a negedge. Counts rising edges until recip_valid is seen at a
  // negedge, and counts tbl_en samples observed while recip_valid was still low.
  task automatic run_until_valid(output int edges, output int early_tbl);
    edges     = 0;
    early_tbl = 0;
    while (!recip_valid && edges < BUDGET) begin
      if (tbl_en) early_tbl++;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  int edges;
  int early;
  logic [RECIP_W-1:0] prev_recip;

  initial begin
    n_tests = 0;
    n_fail  = 0;

    vecs[0] = '{n: 10'd1,    exp_recip: 16'hFFFF, exp_lat: 18};
    vecs[1] = '{n: 10'd3,    exp_recip: 16'd21845, exp_lat: 18};
    vecs[2] = '{n: 10'd1023, exp_recip: 16'd64,   exp_lat: 18};
    vecs[3] = '{n: 10'd0,    exp_recip: 16'd0,    exp_lat: 1};
    vecs[4] = '{n: 10'd2,    exp_recip: 16'd32768, exp_lat: 18};
    vecs[5] = '{n: 10'd500,  exp_recip: 16'd131,  exp_lat: 18};
    vecs[6] = '{n: 10'd7,    exp_recip: 16'd9362, exp_lat: 18};

    // ---- Reset state, then release with N = 1000 ---------------------------
    rst_n          = 1'b0;
    max_iterations = 10'd1000;
    depth_in       = 10'd5;
    depth_valid    = 1'b1;
    repeat (3) step();
    check("rst_recip",  32'(max_iter_recip), 32'd0);
    check("rst_valid",  32'(recip_valid),    32'd0);
    check("rst_ready",  32'(depth_ready),    32'd0);
    check("rst_tbl_en", 32'(tbl_en),         32'd0);
    check("rst_busy",   32'(busy),           32'd1);

    rst_n = 1'b1;
    run_until_valid(edges, early);
    check("rel_latency", 32'(edges),          32'd18);
    check("rel_recip",   32'(max_iter_recip), 32'd65);
    check("rel_no_tbl",  32'(early),          32'd0);
    check("rel_tbl_en",  32'(tbl_en),         32'd1);
    check("rel_tbl_dep", 32'(tbl_depth),      32'd5);
    depth_valid = 1'b0;

    // ---- Table-driven vectors ----------------------------------------------
    prev_recip = 16'd65;
    for (int i = 0; i < 7; i++) begin
      max_iterations = vecs[i].n;
      #1;
      check($sformatf("v%0d_valid_drop", i), 32'(recip_valid), 32'd0);
      step();
      check($sformatf("v%0d_busy_load", i), 32'(busy), 32'd1);
      check($sformatf("v%0d_hold", i), 32'(max_iter_recip), 32'(prev_recip));
      run_until_valid(edges, early);
      check($sformatf("v%0d_latency", i), 32'(edges), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_recip", i), 32'(max_iter_recip), 32'(vecs[i].exp_recip));
      check($sformatf("v%0d_busy_rdy", i), 32'(busy), 32'd0);
      prev_recip = vecs[i].exp_recip;
    end

    // ---- Abort: 1000 -> 500 at DIV cycle 8 ----------------------------------
    max_iterations = 10'd1000;
    step();                    // LOAD
    step();                    // DIV cycle 1
    repeat (7) step();         // DIV cycle 8
    check("abort_busy",  32'(busy),           32'd1);
    check("abort_hold",  32'(max_iter_recip), 32'd9362);
    max_iterations = 10'd500;
    #1;
    check("abort_valid", 32'(recip_valid), 32'd0);
    run_until_valid(edges, early);
    check("abort_latency", 32'(edges),          32'd19);
    check("abort_recip",   32'(max_iter_recip), 32'd131);

    // ---- Limit change in READY with depth_valid held ------------------------
    depth_valid = 1'b1;
    depth_in    = 10'd777;
    #1;
    check("bp_pre_tbl_en", 32'(tbl_en), 32'd1);
    @(negedge clk);
    max_iterations = 10'd250;
    #1;
    check("bp_ready_drop", 32'(depth_ready), 32'd0);
    check("bp_tbl_drop",   32'(tbl_en),      32'd0);
    run_until_valid(edges, early);
    check("bp_no_early",  32'(early),          32'd0);
    check("bp_latency",   32'(edges),          32'd19);
    check("bp_recip",     32'(max_iter_recip), 32'd262);
    check("bp_tbl_en",    32'(tbl_en),         32'd1);
    check("bp_tbl_depth", 32'(tbl_depth),      32'd777);
    depth_valid = 1'b0;

    // ---- Asynchronous reset at DIV cycle 5 ----------------------------------
    max_iterations = 10'd1000;
    step();                    // LOAD
    step();                    // DIV cycle 1
    repeat (4) step();         // DIV cycle 5
    check("ar_busy_div", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_recip", 32'(max_iter_recip), 32'd0);
    check("ar_busy",  32'(busy),           32'd1);
    check("ar_valid", 32'(recip_valid),    32'd0);
    @(negedge clk);
    step();
    rst_n = 1'b1;
    run_until_valid(edges, early);
    check("ar_latency", 32'(edges),          32'd18);
    check("ar_recip2",  32'(max_iter_recip), 32'd65);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/max_iter_recip_ctrl.md
MAX_ITER_RECIP_CTRL -- requirements
Module: max_iter_recip_ctrl

Interface
REQ-001 SHALL have parameter RECIP_W, default 16, reciprocal width (Q0.RECIP_W).
REQ-002 SHALL have parameter DEPTH_W, default 10, width of depth and max_iterations.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port max_iterations, input, DEPTH_W: run-time iteration limit, may change at any cycle.
REQ-006 SHALL have port depth_in, input, DEPTH_W: pixel depth from the iteration engine.
REQ-007 SHALL have port depth_valid, input, 1: depth_in is valid this cycle.
REQ-008 SHALL have port depth_ready, output, 1: controller accepts depth_in this cycle.
REQ-009 SHALL have port tbl_en, output, 1: enable to the colour table stage.
REQ-010 SHALL have port tbl_depth, output, DEPTH_W: depth forwarded to the colour table.
REQ-011 SHALL have port max_iter_recip, output, RECIP_W: floor(2^RECIP_W / N), saturated.
REQ-012 SHALL have port recip_valid, output, 1: max_iter_recip matches the current max_iterations.
REQ-013 SHALL have port busy, output, 1: division in progress (LOAD or DIV state).

Function
REQ-014 SHALL implement states LOAD, DIV, READY.
REQ-015 In LOAD: latch N_q <= max_iterations, remainder <= 0, quotient <= 0, bit counter <= RECIP_W; next state is DIV.
REQ-016 In DIV: one restoring-division step per cycle, over bits RECIP_W down to 0 of dividend 2^RECIP_W (RECIP_W+1 = 17 cycles); remainder width DEPTH_W+1.
REQ-017 After the step for bit 0, the next state SHALL be READY, with max_iter_recip <= quotient saturated to all-ones when the quotient is >= 2^RECIP_W.
REQ-018 If N_q == 0, LOAD SHALL go directly to READY with max_iter_recip <= 0 (no DIV cycles).
REQ-019 Latency: recip_valid SHALL rise exactly 18 cycles after LOAD is entered (N != 0), 1 cycle for N == 0.
REQ-020 In READY: recip_valid = 1, busy = 0.
REQ-021 Any cycle in DIV or READY where max_iterations != N_q SHALL transition to LOAD on the next edge; in DIV this aborts and restarts the division.
REQ-022 recip_valid SHALL be combinationally low in any cycle where max_iterations != N_q.
REQ-023 max_iter_recip SHALL hold its previous value during LOAD/DIV; it updates only on entry to READY.
REQ-024 depth_ready SHALL equal recip_valid (combinational).
REQ-025 tbl_en SHALL equal depth_valid AND depth_ready; tbl_depth SHALL equal depth_in.
REQ-026 A depth presented while depth_ready = 0 SHALL NOT be forwarded; the upstream holds it (valid/ready handshake, no drop, no duplicate).
REQ-027 busy SHALL be 1 in LOAD and DIV, else 0.

Reset
REQ-028 While rst_n = 0: state = LOAD, max_iter_recip = 0, N_q = 0, quotient = 0, remainder = 0, counter = 0, recip_valid = 0, depth_ready = 0, tbl_en = 0, busy = 1.
REQ-029 On rst_n release, the controller SHALL compute from LOAD on the first clock edge, using max_iterations sampled at that edge.
REQ-030 Reset asserted mid-DIV SHALL abort immediately (asynchronously) to the REQ-028 values.

Verification
REQ-031 max_iterations = 1000, reset release -> recip_valid rises 18 cycles after LOAD; max_iter_recip = 65 (0x0041).
REQ-032 max_iterations = 1 -> max_iter_recip = 0xFFFF (saturated); max_iterations = 3 -> 21845 (0x5555); max_iterations = 1023 -> 64.
REQ-033 max_iterations = 0 -> max_iter_recip = 0 with recip_valid 1 cycle after LOAD; no DIV cycles occur.
REQ-034 Change max_iterations 1000 -> 500 at DIV cycle 8 -> division restarts; recip_valid rises 18 cycles after the new LOAD; result = 131; the old value 65 is never flagged valid.
REQ-035 depth_valid held high across a max_iterations change in READY -> depth_ready and tbl_en low in the change cycle and throughout recompute; no tbl_en pulse before recip_valid = 1.
REQ-036 rst_n pulsed low at DIV cycle 5 -> outputs take REQ-028 values asynchronously; a clean recompute follows release.
